add_sequencer: RTL and testbench
================================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter: WORDS, default 4, number of 16-bit words per operand (legal 1..8).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 a  input  16*WORDS  operand A, word 0 = bits [15:0].
REQ-006 b  input  16*WORDS  operand B.
REQ-007 cin  input  1  carry into word 0.
REQ-008 sub  input  1  subtract select (present only with ADD_SEQ_SUB_EN, see REQ-027).
REQ-009 busy  output  1  high from accepted start until done cycle ends.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 sum  output  16*WORDS  result register.
REQ-012 cout  output  1  carry out of the most significant word.

Function
REQ-013 Block SHALL instantiate exactly one 16-bit prefix_adder (term0, term1, cin, sum, cout) and time-multiplex it over the operand words; no other adder in the datapath.
REQ-014 FSM states: IDLE, RUN, DONE; busy = (state != IDLE).
REQ-015 IDLE: start=1 at edge E0 -> latch a, b, initial carry (cin, or 1 when subtracting), clear sum to 0, word index to 0, go to RUN.
REQ-016 RUN: each edge writes adder sum of word[idx] into sum[16*idx+:16], loads carry register from adder cout, increments idx.
REQ-017 Adder inputs in RUN: term0 = latched A word[idx], term1 = latched B word[idx] (inverted when subtracting), cin = carry register.
REQ-018 At edge E_WORDS (last word written) go to DONE; cout takes final adder cout at that same edge.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE at next edge; latency accept-edge to done-high = WORDS cycles.
REQ-020 sum and cout SHALL hold after DONE until the next accepted start.
REQ-021 start while busy=1 (RUN or DONE) SHALL be ignored, no queuing; start in same cycle as done is ignored.
REQ-022 Changes on a, b, cin, sub after acceptance SHALL not affect the running operation.
REQ-023 Arithmetic is modulo 2^(16*WORDS); carry out of word k feeds word k+1 only through the carry register.

Reset
REQ-024 rst=1 SHALL asynchronously force: state IDLE, busy 0, done 0, sum 0, cout 0, idx 0, carry register 0, latched operands 0.
REQ-025 rst asserted mid-operation aborts it; no done pulse follows for the aborted operation.
REQ-026 After rst deasserts, first start is accepted on the first rising edge with start=1.

Configuration
REQ-027 Macro ADD_SEQ_SUB_EN: when defined, sub port exists; sub=1 at acceptance latches ~b and initial carry 1 (cin ignored), computing A-B, cout=1 meaning no borrow. When undefined, sub port absent, addition only, cin always used.

Verification
REQ-028 WORDS=4, a=0x0000_0000_FFFF_FFFF, b=0x1, cin=0 -> done 4 cycles after accept, sum=0x0000_0001_0000_0000, cout=0.
REQ-029 WORDS=4, a=all 1s, b=0, cin=1 -> sum=0, cout=1; busy high exactly 5 cycles.
REQ-030 WORDS=1, a=0xEE48, b=0x5208, cin=1 -> done 1 cycle after accept, sum=0x4051, cout=1; a=0x6978, b=0x61A8, cin=0 -> sum=0xCB20, cout=0.
REQ-031 Start pulsed again during RUN and during DONE -> ignored, single done pulse, result unchanged; operands changed mid-run -> result of latched operands.
REQ-032 rst pulsed after 2 RUN edges -> sum=0, cout=0, busy=0 immediately; no done pulse; next start completes normally.
REQ-033 ADD_SEQ_SUB_EN defined, WORDS=4, a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.

Source files
------------

// File: rtl/add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : add_sequencer (with helper module prefix_adder)
//  Purpose  : Multi-word adder that reuses one 16-bit Kogge-Stone adder
//             across WORDS operand words. One word is processed per clock,
//             starting with the least significant word. The carry between
//             words is passed through a carry register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WORDS  number of 16-bit words per operand (1..8), default 4
//  Optional feature
//    ADD_SEQ_SUB_EN  when defined, adds the 'sub' port. With sub=1 at accept
//                    time the block computes a - b. In that case
//                    cout=1 means no borrow.
//  Ports
//    clk    in   clock; all state changes on the rising edge
//    rst    in   asynchronous active-high reset
//    start  in   request a new operation; sampled only while busy=0
//    a, b   in   operands, 16*WORDS bits; word 0 = bits [15:0]
//    cin    in   carry into word 0
//    sub    in   subtract select (only when ADD_SEQ_SUB_EN is defined)
//    busy   out  high from the accepting edge until the done cycle ends
//    done   out  one-cycle pulse; sum/cout are valid
//    sum    out  result register, 16*WORDS bits
//    cout   out  carry out of the most significant word
// ============================================================================

// ----------------------------------------------------------------------------
//  prefix_adder : 16-bit Kogge-Stone adder with carry in/out.
//    term0, term1  in   addends
//    cin           in   carry into bit 0
//    sum           out  term0 + term1 + cin, low 16 bits
//    cout          out  carry out of bit 15
// ----------------------------------------------------------------------------
module prefix_adder (
  input  logic [15:0] term0,
  input  logic [15:0] term1,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] prop;
  logic [15:0] gen;
  logic [15:0] g_cur;
  logic [15:0] p_cur;
  logic [15:0] g_nxt;
  logic [15:0] p_nxt;
  logic [15:0] carries;

  assign prop = term0 ^ term1;
  assign gen  = term0 & term1;

  always_comb begin
    // Fold cin into the generate term of bit 0. After the prefix tree,
    // g_cur[i] is then the carry out of bit i.
    g_cur   = {gen[15:1], gen[0] | (prop[0] & cin)};
    p_cur   = prop;
    g_nxt   = '0;
    p_nxt   = '0;
    for (int d = 1; d < 16; d = d * 2) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = d; i < 16; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-d]);
        p_nxt[i] = p_cur[i] & p_cur[i-d];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    carries = {g_cur[14:0], cin};
    sum     = prop ^ carries;
    cout    = g_cur[15];
  end

endmodule

// ----------------------------------------------------------------------------
//  add_sequencer : sequences the shared prefix_adder over the operand words.
// ----------------------------------------------------------------------------
module add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout
);

  localparam int         WIDTH    = 16 * WORDS;
  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic             carry;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;

  logic [15:0]      add_term0;
  logic [15:0]      add_term1;
  logic [15:0]      add_sum;
  logic             add_cout;

  // Operand values and initial carry used when a start is accepted. For
  // subtraction, B is inverted when it is latched and the carry is set to 1.
  // The RUN datapath is then identical for add and subtract.
  logic [WIDTH-1:0] b_accept;
  logic             carry_accept;

`ifdef ADD_SEQ_SUB_EN
  assign b_accept     = sub ? ~b : b;
  assign carry_accept = sub ? 1'b1 : cin;
`else
  assign b_accept     = b;
  assign carry_accept = cin;
`endif

  // Word selection for the shared adder. idx stays below WORDS, so the
  // part-select is always in range.
  assign add_term0 = a_lat[16*idx +: 16];
  assign add_term1 = b_lat[16*idx +: 16];

  prefix_adder u_adder (
    .term0 (add_term0),
    .term1 (add_term1),
    .cin   (carry),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      a_lat <= '0;
      b_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= a;
            b_lat <= b_accept;
            carry <= carry_accept;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sum[16*idx +: 16] <= add_sum;
          carry             <= add_cout;
          if (idx == LAST_IDX) begin
            // The last word has been written. Publish the final carry and
            // raise done for the following cycle.
            cout  <= add_cout;
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end

        DONE: begin
          // start is ignored here. sum and cout hold until the next accept.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sequencer
//  Purpose  : Self-checking bench for add_sequencer. A WORDS=4 instance is
//             compared every cycle against a transaction-level model. A
//             WORDS=1 instance is checked with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sequencer;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // WORDS=4 instance
  logic        start4 = 1'b0;
  logic [63:0] a4 = '0;
  logic [63:0] b4 = '0;
  logic        cin4 = 1'b0;
  logic        sub4 = 1'b0;
  logic        busy4;
  logic        done4;
  logic [63:0] sum4;
  logic        cout4;

  // WORDS=1 instance
  logic        start1 = 1'b0;
  logic [15:0] a1 = '0;
  logic [15:0] b1 = '0;
  logic        cin1 = 1'b0;
  logic        sub1 = 1'b0;
  logic        busy1;
  logic        done1;
  logic [15:0] sum1;
  logic        cout1;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  add_sequencer #(.WORDS(W)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
`ifdef ADD_SEQ_SUB_EN
    .sub   (sub4),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  add_sequencer #(.WORDS(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef ADD_SEQ_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the WORDS=4 instance -------
  // mk = -1 when idle. Otherwise mk is the number of edges since the accept
  // edge. The full answer comes from plain wide arithmetic.
  function automatic logic [64:0] model_res(input logic [63:0] x, input logic [63:0] y,
                                            input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 65'd1;
    return {1'b0, x} + {1'b0, y} + {64'd0, c};
  endfunction

  int          mk = -1;
  logic [64:0] mres = '0;
  logic [63:0] hold_sum = '0;
  logic        hold_cout = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk        <= -1;
      mres      <= '0;
      hold_sum  <= '0;
      hold_cout <= 1'b0;
    end else if (mk < 0) begin
      if (start4) begin
        mk   <= 0;
        mres <= model_res(a4, b4, cin4, sub4);
      end
    end else if (mk == W) begin
      hold_sum  <= mres[63:0];
      hold_cout <= mres[64];
      mk        <= -1;
    end else begin
      mk <= mk + 1;
    end
  end

  // During a run, only the words already processed hold result bits. The
  // remaining words are still zero.
  function automatic logic [63:0] exp_sum();
    logic [63:0] m;
    if (mk < 0)  return hold_sum;
    if (mk >= W) return mres[63:0];
    m = (64'd1 << (16 * mk)) - 64'd1;
    return mres[63:0] & m;
  endfunction

  function automatic logic exp_cout();
    if (mk < 0)  return hold_cout;
    if (mk == W) return mres[64];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_busy", {63'd0, busy4}, {63'd0, mk >= 0});
      check("m_done", {63'd0, done4}, {63'd0, mk == W});
      check("m_sum",  sum4, exp_sum());
      check("m_cout", {63'd0, cout4}, {63'd0, exp_cout()});
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op4(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                         input logic su, output int lat, output int bcnt);
    a4 = av; b4 = bv; cin4 = ci; sub4 = su; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) bcnt++;
      tick();
      lat++;
    end
    while (busy4 && bcnt < 40) begin
      bcnt++;
      tick();
    end
  endtask

  task automatic run_op1(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         output int lat);
    a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
    tick();
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat;
    int bc;
    int nd;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    vecs[2] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busy", {63'd0, busy4}, 64'd0);
    check("rst_sum",  sum4, 64'd0);
    check("rst_done", {63'd0, done4}, 64'd0);
    rst = 1'b0;
    tick();

    // Carry ripples across a word boundary.
    run_op4(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, bc);
    check("carry_ripple_latency", lat, 4);
    check("carry_ripple_sum", sum4, 64'h0000_0001_0000_0000);
    check("carry_ripple_cout", {63'd0, cout4}, 64'd0);

    // All ones plus cin wraps to zero. Also check the busy length.
    run_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat, bc);
    check("wrap_sum", sum4, 64'h0);
    check("wrap_cout", {63'd0, cout4}, 64'd1);
    check("wrap_busy_cycles", bc, 5);

    foreach (vecs[i]) begin
      run_op4(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, lat, bc);
      check("vec_sum", sum4, vecs[i].s);
      check("vec_cout", {63'd0, cout4}, {63'd0, vecs[i].co});
    end

    // Start during RUN and during DONE is ignored. Operand changes after
    // accept have no effect.
    a4 = 64'h1234_5678_9ABC_DEF0; b4 = 64'h1111_1111_1111_1111; cin4 = 1'b1;
    start4 = 1'b1;
    tick();
    a4 = 64'hDEAD_BEEF_0000_0000; b4 = 64'h5555; cin4 = 1'b0;
    start4 = 1'b1;
    tick();
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done4) begin
        nd++;
        start4 = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      tick();
    end
    start4 = 1'b0;
    check("ignore_done_count", nd, 1);
    check("ignore_sum", sum4, 64'h2345_6789_ABCD_F002);
    check("ignore_cout", {63'd0, cout4}, 64'd0);
    check("ignore_busy_after", {63'd0, busy4}, 64'd0);

    // Reset in the middle of an operation.
    a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'h1; cin4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy4}, 64'd0);
    check("abort_sum", sum4, 64'd0);
    check("abort_cout", {63'd0, cout4}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) nd++;
      tick();
    end
    check("abort_no_done", nd, 0);
    run_op4(64'h3, 64'h4, 1'b0, 1'b0, lat, bc);
    check("after_abort_sum", sum4, 64'h7);
    check("after_abort_latency", lat, 4);

`ifdef ADD_SEQ_SUB_EN
    run_op4(64'h5, 64'h7, 1'b0, 1'b1, lat, bc);
    check("sub_neg_sum", sum4, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_neg_cout", {63'd0, cout4}, 64'd0);
    run_op4(64'h7, 64'h5, 1'b1, 1'b1, lat, bc);
    check("sub_pos_sum", sum4, 64'h2);
    check("sub_pos_cout", {63'd0, cout4}, 64'd1);
    sub4 = 1'b0;
`endif

    // Single-word instance
    run_op1(16'hEE48, 16'h5208, 1'b1, lat);
    check("w1_latency", lat, 1);
    check("w1_sum_a", {48'd0, sum1}, 64'h4051);
    check("w1_cout_a", {63'd0, cout1}, 64'd1);
    run_op1(16'h6978, 16'h61A8, 1'b0, lat);
    check("w1_sum_b", {48'd0, sum1}, 64'hCB20);
    check("w1_cout_b", {63'd0, cout1}, 64'd0);
    check("w1_idle", {63'd0, busy1}, 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
